// File: rtl/average_pooling_cfg.sv
// 2x2 average-pooling stage with run-time stride (1 or 2), one-row line buffer,
// end-of-frame marker and valid/ready backpressure on both sides.
module average_pooling_cfg #(
  parameter int IMG_W    = 62,
  parameter int IMG_H    = 62,
  parameter int IN_W     = 12,
  parameter int OUT_W    = 8,
  parameter int SAT_MODE = 0
) (
  input  logic              clk_200mhz,
  input  logic              reset,
  input  logic              stride_sel,
  input  logic [IN_W-1:0]   pixel_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [OUT_W-1:0]  pixel_out,
  output logic              valid_out,
  output logic              last_out,
  input  logic              ready_in
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  // Last odd index: with odd dimensions the trailing column/row is dropped.
  localparam logic [CW-1:0] COL_LAST2 = CW'((IMG_W / 2) * 2 - 1);
  localparam logic [RW-1:0] ROW_LAST2 = RW'((IMG_H / 2) * 2 - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             stride_q, stride_d;
  logic [IN_W-1:0]  lb_q [IMG_W];
  logic [IN_W-1:0]  prev_cur_q, prev_up_q, up_pix;
  logic             valid_q, last_q;
  logic [OUT_W-1:0] pix_q;

  logic             accept, in_win, emit, is_last;
  logic [IN_W+1:0]  sum;
  logic [IN_W-1:0]  avg;
  logic [OUT_W-1:0] conv;

  assign ready_out = !valid_q || ready_in;
  assign accept    = valid_in && ready_out;
  assign up_pix    = lb_q[col_q];

  assign pixel_out = pix_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;

  // Stride is latched at (0,0) and no window ever completes there, so stride_q
  // is already valid for every emitting accept of the frame.
  assign in_win  = (row_q != '0) && (col_q != '0) &&
                   (!stride_q || (row_q[0] && col_q[0]));
  assign emit    = accept && in_win;
  assign is_last = stride_q ? ((row_q == ROW_LAST2) && (col_q == COL_LAST2))
                            : ((row_q == ROW_LAST)  && (col_q == COL_LAST));

  assign sum = {2'b00, prev_up_q} + {2'b00, up_pix} +
               {2'b00, prev_cur_q} + {2'b00, pixel_in};
  assign avg = IN_W'(sum >> 2);

  generate
    if (SAT_MODE == 0) begin : g_sat
      localparam logic [IN_W-1:0] OMAX = IN_W'((1 << OUT_W) - 1);
      assign conv = (avg > OMAX) ? '1 : OUT_W'(avg);
    end else begin : g_shift
      assign conv = OUT_W'(avg >> (IN_W - OUT_W));
    end
  endgenerate

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    stride_d = stride_q;
    if (accept) begin
      if ((col_q == '0) && (row_q == '0)) stride_d = stride_sel;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_200mhz) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      stride_q   <= 1'b0;
      prev_cur_q <= '0;
      prev_up_q  <= '0;
      valid_q    <= 1'b0;
      pix_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      stride_q <= stride_d;
      if (accept) begin
        prev_cur_q <= pixel_in;
        prev_up_q  <= up_pix;
      end
      // emit implies accept, which implies the previous output is gone or leaving.
      if (emit) begin
        valid_q <= 1'b1;
        pix_q   <= conv;
        last_q  <= is_last;
      end else if (valid_q && ready_in) begin
        valid_q <= 1'b0;
        pix_q   <= '0;
        last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_200mhz) begin
    if (accept) lb_q[col_q] <= pixel_in;
  end

endmodule
